// File: rtl/hazard_if.sv
// Hazard controller bundle: pipeline register indices and enables in, stall/flush/forward
// controls out. The master side (pipeline) drives the observations; the slave side
// (hazard_ctrl) returns the controls.
// Build option: HAZARD_PERF_EN adds the StallCycles/FlushCount/FaultFlag counter outputs.
interface hazard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]                ResultSrcE;
  logic                      RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]                ForwardAE, ForwardBE;
  logic                      StallF, StallD, StallE, StallM;
  logic                      FlushD, FlushE, FlushW;
  logic                      MemFault;
  logic [1:0]                State;
`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0]      StallCycles, FlushCount, FaultFlag;
`endif

  // Counter width must be usable even when the counters are compiled out
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("hazard_if: CNT_WIDTH must be >= 1");
  end

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    output RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemFault, State
`ifdef HAZARD_PERF_EN
    , input StallCycles, FlushCount, FaultFlag
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    input  RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemFault, State
`ifdef HAZARD_PERF_EN
    , output StallCycles, FlushCount, FaultFlag
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core. Owns every pipeline-hold
// decision: E-stage forwarding, load-use stall, branch flush and the data-memory wait
// FSM with timeout. All controls are combinational from the inputs and the registered
// FSM state, so a hazard is acted on in the same cycle it appears.
// Build option: HAZARD_PERF_EN adds saturating stall/flush/fault performance counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);
  // A timeout of 1 still needs a one-bit counter
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("hazard_ctrl: MEM_TIMEOUT and CNT_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FAULT    = 2'b10
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_fault;

  logic w_mem_stall;
  logic w_freeze;
  logic w_branch;
  logic w_lu_hit;
  logic w_load_use;
  logic w_stall_f;
  logic w_flush_e;

  // Operand forwarding: M has priority over W, and x0 is never forwarded
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_fwd
    logic [REG_ADDR_WIDTH-1:0] w_rs;
    logic [1:0]                w_sel;
    assign w_rs = (gi == 0) ? hz.Rs1E : hz.Rs2E;
    // Pick the youngest in-flight producer of this E-stage source register
    always_comb begin
      w_sel = 2'b00;
      if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == w_rs))
        w_sel = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == w_rs))
        w_sel = 2'b01;
    end
  end
  assign hz.ForwardAE = g_fwd[0].w_sel;
  assign hz.ForwardBE = g_fwd[1].w_sel;

  // Freeze beats branch flush, which beats load-use; a squashed D instruction
  // cannot cause a load-use stall
  assign w_mem_stall = hz.MemReqM && !hz.MemReadyM;
  assign w_freeze    = w_mem_stall || (r_state == ST_FAULT);
  assign w_branch    = hz.PCSrcE && !w_freeze;
  assign w_lu_hit    = (hz.ResultSrcE == 2'b01) && (hz.RdE != '0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign w_load_use  = w_lu_hit && !hz.PCSrcE && !w_freeze;

  assign w_stall_f = w_freeze || w_load_use;
  assign w_flush_e = w_branch || w_load_use;

  assign hz.StallF   = w_stall_f;
  assign hz.StallD   = w_stall_f;
  assign hz.StallE   = w_freeze;
  assign hz.StallM   = w_freeze;
  assign hz.FlushD   = w_branch;
  assign hz.FlushE   = w_flush_e;
  assign hz.FlushW   = w_freeze;
  assign hz.MemFault = r_fault;
  assign hz.State    = r_state;

  // Memory wait sequencer: count consecutive not-ready cycles, fault when exhausted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state <= ST_MEM_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_MEM_WAIT: begin
          // A withdrawn request ends the wait just like a completed one
          if (!hz.MemReqM || hz.MemReadyM) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic       w_to_fault;
  logic [2:0] w_perf_inc;

  assign w_to_fault = (r_state == ST_MEM_WAIT) && w_mem_stall && (r_cnt == CNT_LAST);
  assign w_perf_inc = {w_to_fault, w_flush_e, w_stall_f};

  for (gi = 0; gi < 3; gi++) begin : g_perf
    logic [CNT_WIDTH-1:0] r_count;
    // Saturating event counter
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_count <= '0;
      else if (w_perf_inc[gi] && (r_count != '1))
        r_count <= r_count + 1'b1;
    end
  end

  assign hz.StallCycles = g_perf[0].r_count;
  assign hz.FlushCount  = g_perf[1].r_count;
  assign hz.FaultFlag   = g_perf[2].r_count;
`endif
endmodule
